maxpool_2x2: RTL and testbench

MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

---
 rtl/maxpool_2x2_if.sv | 37 +++
 rtl/maxpool_2x2.sv | 185 ++++++++++++++++++
 tb/tb_maxpool_2x2.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_2x2_if.sv
// Handshake and buffer-port bundle for the 2x2 max-pool engine.
// The slave side is the pooling engine; the master side is the host plus the layer-1 buffer.
interface maxpool_2x2_if;
  logic       start;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       busy;
  logic       done;

  modport master (
    output start,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_valid,
    output out_data,
    output out_addr,
    output busy,
    output done
  );
endinterface

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over an IN_W x IN_W feature map held in a synchronous buffer.
// Reads are issued gap-free in window order; one pooled word emerges every 4 cycles.
module maxpool_2x2 #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 13
) (
  input  logic         clk,
  input  logic         rst,
  maxpool_2x2_if.slave bus
);

  localparam int              CW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [1:0]      IDLE     = 2'd0;
  localparam logic [1:0]      READ     = 2'd1;
  localparam logic [1:0]      DRAIN    = 2'd2;
  localparam logic [CW-1:0]   LAST_P   = CW'(OUT_W - 1);
  localparam logic [7:0]      LAST_WIN = 8'(OUT_W * OUT_W - 1);
  localparam logic [9:0]      ROW_STEP = 10'(IN_W);
  localparam logic [9:0]      ROW_PAIR = 10'(2 * IN_W);

  // Read-issue side
  logic [1:0]    state_q,   state_d;
  logic [1:0]    sub_q,     sub_d;
  logic [CW-1:0] pcol_q,    pcol_d;
  logic [CW-1:0] prow_q,    prow_d;
  logic          rd_en_q,   rd_en_d;
  logic [9:0]    rd_addr_q, rd_addr_d;
  logic          busy_q,    busy_d;

  // Data-return side, one cycle behind the issue side
  logic          vld_q,       vld_d;
  logic [1:0]    dsub_q,      dsub_d;
  logic [7:0]    acc_q,       acc_d;
  logic [7:0]    win_q,       win_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q,  out_data_d;
  logic [7:0]    out_addr_q,  out_addr_d;
  logic          done_q,      done_d;

  logic       last_read;
  logic       start_acc;
  logic [7:0] max_val;

  assign last_read = (sub_q == 2'd3) && (pcol_q == LAST_P) && (prow_q == LAST_P);
  assign start_acc = (state_q == IDLE) && bus.start;
  assign max_val   = (bus.rd_data > acc_q) ? bus.rd_data : acc_q;

  // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          sub_d   = 2'd0;
          pcol_d  = '0;
          prow_d  = '0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (last_read) begin
          state_d = DRAIN;
          sub_d   = 2'd0;
          pcol_d  = '0;
          prow_d  = '0;
        end else if (sub_q != 2'd3) begin
          sub_d = sub_q + 2'd1;
        end else begin
          sub_d = 2'd0;
          if (pcol_q == LAST_P) begin
            pcol_d = '0;
            prow_d = prow_q + CW'(1);
          end else begin
            pcol_d = pcol_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // The final result has just been strobed; the map is complete.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sub_d   = 2'd0;
        pcol_d  = '0;
        prow_d  = '0;
        busy_d  = 1'b0;
      end
    endcase

    rd_en_d = (state_d == READ);
    // Sub-index bit 0 selects the right column, bit 1 the lower row of the window.
    if (rd_en_d) begin
      rd_addr_d = ({{(10 - CW){1'b0}}, prow_d} * ROW_PAIR)
                + {{(9 - CW){1'b0}}, pcol_d, 1'b0}
                + {9'd0, sub_d[0]}
                + (sub_d[1] ? ROW_STEP : 10'd0);
    end else begin
      rd_addr_d = 10'd0;
    end
  end

  always_comb begin
    vld_d       = rd_en_q;
    dsub_d      = rd_en_q ? sub_q : 2'd0;
    acc_d       = acc_q;
    win_d       = win_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;

    if (start_acc) begin
      win_d = 8'd0;
      acc_d = 8'd0;
    end

    if (vld_q) begin
      acc_d = (dsub_q == 2'd0) ? bus.rd_data : max_val;
      if (dsub_q == 2'd3) begin
        out_valid_d = 1'b1;
        out_data_d  = max_val;
        out_addr_d  = win_q;
        win_d       = win_q + 8'd1;
        done_d      = (win_q == LAST_WIN);
      end
    end
  end

  // NOTE: the asynchronous reset clears every register, so an aborted map leaves nothing in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sub_q       <= 2'd0;
      pcol_q      <= '0;
      prow_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 10'd0;
      busy_q      <= 1'b0;
      vld_q       <= 1'b0;
      dsub_q      <= 2'd0;
      acc_q       <= 8'd0;
      win_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_addr_q  <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      sub_q       <= sub_d;
      pcol_q      <= pcol_d;
      prow_q      <= prow_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      vld_q       <= vld_d;
      dsub_q      <= dsub_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2: a buffer model answers reads one cycle late and a
// negedge monitor compares every read address and pooled word against values computed here.
module tb_maxpool_2x2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxpool_2x2_if bus();

  maxpool_2x2 #(.IN_W(26), .OUT_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Layer-1 buffer model: synchronous read, data one cycle after rd_en.
  logic [7:0] mem [0:675];
  logic [7:0] buf_q = 8'd0;
  always @(posedge clk) if (bus.rd_en) buf_q <= mem[bus.rd_addr];
  assign bus.rd_data = buf_q;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int s_edge   = 0;
  bit mon_en   = 1'b0;
  always @(posedge clk) edge_cnt++;

  int rd_cnt, rd_first, rd_last, addr_err, idle_err;
  int ov_cnt, ov_first, ov_last, spacing_err, oaddr_err, data_err, hold_err;
  int done_cnt, done_cycle, done_err;
  logic [7:0] got [0:168];
  logic [7:0] prev_data = 8'd0;
  logic [7:0] prev_addr = 8'd0;
  bit         prev_rst  = 1'b0;

  // Cycle 1 is the cycle right after the edge that sampled start.
  function automatic int cyc();
    return edge_cnt - s_edge + 1;
  endfunction

  function automatic logic [9:0] rd_exp(input int k);
    int w, s, pr, pc;
    w  = k / 4;
    s  = k % 4;
    pr = w / 13;
    pc = w % 13;
    return 10'(2 * pr * 26 + 2 * pc + (s % 2) + (s / 2) * 26);
  endfunction

  function automatic logic [7:0] win_max(input int w);
    logic [7:0] m;
    m = 8'd0;
    for (int s = 0; s < 4; s++) begin
      logic [9:0] a;
      a = rd_exp(w * 4 + s);
      if (mem[a] > m) m = mem[a];
    end
    return m;
  endfunction

  always @(negedge clk) begin
    int c;
    c = cyc();
    if (mon_en && rst) begin
      if (bus.rd_en) begin
        if (rd_cnt == 0) rd_first = c;
        rd_last = c;
        if (bus.rd_addr !== rd_exp(rd_cnt)) addr_err++;
        rd_cnt++;
      end else if (bus.rd_addr !== 10'd0) begin
        idle_err++;
      end
      if (bus.out_valid) begin
        if (ov_cnt == 0) ov_first = c;
        else if (c - ov_last != 4) spacing_err++;
        ov_last = c;
        if (bus.out_addr !== 8'(ov_cnt)) oaddr_err++;
        if (ov_cnt < 169) begin
          got[ov_cnt] = bus.out_data;
          if (bus.out_data !== win_max(ov_cnt)) data_err++;
        end
        ov_cnt++;
      end else if (prev_rst && (bus.out_data !== prev_data || bus.out_addr !== prev_addr)) begin
        hold_err++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cycle = c;
        if (!bus.out_valid || ov_cnt != 169) done_err++;
      end
    end
    prev_rst  = rst;
    prev_data = bus.out_data;
    prev_addr = bus.out_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_en = 1'b0;
    rd_cnt = 0; rd_first = 0; rd_last = 0; addr_err = 0; idle_err = 0;
    ov_cnt = 0; ov_first = 0; ov_last = 0; spacing_err = 0; oaddr_err = 0;
    data_err = 0; hold_err = 0; done_cnt = 0; done_cycle = 0; done_err = 0;
    for (int i = 0; i < 169; i++) got[i] = 8'hxx;
  endtask

  // Call just after a rising edge; start is sampled at the next one.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    s_edge = edge_cnt;
    mon_en = 1'b1;
  endtask

  // Pools one map; optional extra start pulse in read cycle inj. Returns just after the edge ending the done cycle.
  task automatic run_map(input int inj, output logic busy_at_done);
    clear_mon();
    pulse_start();
    busy_at_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      bus.start = (inj > 0 && cyc() == inj);
      if (done_cnt > 0) break;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    busy_at_done = bus.busy;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 676; a++) mem[a] = 8'(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int   wins [4];
    int   nff;
    int   ov_before;
    wins = '{0, 44, 100, 168};
    bus.start = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en",     32'(bus.rd_en),     32'd0);
    check("rst_rd_addr",   32'(bus.rd_addr),   32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp map with full timing checks
    fill_ramp();
    run_map(0, bad);
    check("ramp_w0",        32'(got[0]),   32'd27);
    check("ramp_w12",       32'(got[12]),  32'd51);
    check("ramp_w168",      32'(got[168]), 32'd163);
    check("ramp_ov_cnt",    32'(ov_cnt),   32'd169);
    check("ramp_done_cnt",  32'(done_cnt), 32'd1);
    check("ramp_done_w168", 32'(done_err), 32'd0);
    check("ramp_rd_first",  32'(rd_first), 32'd1);
    check("ramp_rd_last",   32'(rd_last),  32'd676);
    check("ramp_rd_cnt",    32'(rd_cnt),   32'd676);
    check("ramp_ov_first",  32'(ov_first), 32'd6);
    check("ramp_done_cyc",  32'(done_cycle), 32'd678);
    check("ramp_busy_done", 32'(bad),      32'd1);
    check("ramp_busy_low",  32'(bus.busy), 32'd0);
    check("ramp_done_low",  32'(bus.done), 32'd0);
    check("ramp_addr_seq",  32'(addr_err), 32'd0);
    check("ramp_idle_addr", 32'(idle_err), 32'd0);
    check("ramp_oaddr",     32'(oaddr_err), 32'd0);
    check("ramp_spacing",   32'(spacing_err), 32'd0);
    check("ramp_data",      32'(data_err), 32'd0);
    check("ramp_hold",      32'(hold_err), 32'd0);

    // Start in the cycle right after done
    run_map(0, bad);
    check("b2b_ov_cnt",   32'(ov_cnt),   32'd169);
    check("b2b_ov_first", 32'(ov_first), 32'd6);
    check("b2b_w0",       32'(got[0]),   32'd27);
    check("b2b_data",     32'(data_err), 32'd0);
    check("b2b_addr_seq", 32'(addr_err), 32'd0);

    // Single 0xFF in each window position
    for (int p = 0; p < 4; p++) begin
      int w, a;
      for (int i = 0; i < 676; i++) mem[i] = 8'h10;
      w = wins[p];
      a = 2 * (w / 13) * 26 + 2 * (w % 13) + (p % 2) + (p / 2) * 26;
      mem[a] = 8'hFF;
      run_map(0, bad);
      nff = 0;
      for (int i = 0; i < 169; i++) if (got[i] === 8'hFF) nff++;
      check($sformatf("pos%0d_hit", p),   32'(got[w]), 32'hFF);
      check($sformatf("pos%0d_nff", p),   32'(nff),    32'd1);
      check($sformatf("pos%0d_data", p),  32'(data_err), 32'd0);
      check($sformatf("pos%0d_other", p), 32'(got[(w + 1) % 169]), 32'h10);
    end

    // Start pulsed while busy
    fill_ramp();
    run_map(100, bad);
    check("sbusy_ov_cnt",   32'(ov_cnt),     32'd169);
    check("sbusy_done_cnt", 32'(done_cnt),   32'd1);
    check("sbusy_rd_cnt",   32'(rd_cnt),     32'd676);
    check("sbusy_done_cyc", 32'(done_cycle), 32'd678);
    check("sbusy_addr_seq", 32'(addr_err),   32'd0);
    check("sbusy_data",     32'(data_err),   32'd0);

    // Reset in the middle of window 50
    clear_mon();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (cyc() >= 202) break;
    end
    rst = 1'b0;
    #1;
    check("mid_rd_en",     32'(bus.rd_en),     32'd0);
    check("mid_rd_addr",   32'(bus.rd_addr),   32'd0);
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_out_data",  32'(bus.out_data),  32'd0);
    check("mid_out_addr",  32'(bus.out_addr),  32'd0);
    check("mid_busy",      32'(bus.busy),      32'd0);
    check("mid_done",      32'(bus.done),      32'd0);
    ov_before = ov_cnt;
    check("mid_ov_before", 32'(ov_before), 32'd50);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_ov",   32'(ov_cnt),   32'(ov_before));
    check("mid_no_done", 32'(done_cnt), 32'd0);
    check("mid_idle",    32'(bus.busy), 32'd0);
    run_map(0, bad);
    check("post_ov_cnt",   32'(ov_cnt),    32'd169);
    check("post_oaddr",    32'(oaddr_err), 32'd0);
    check("post_w0",       32'(got[0]),    32'd27);
    check("post_data",     32'(data_err),  32'd0);
    check("post_done_cnt", 32'(done_cnt),  32'd1);
    check("post_rd_first", 32'(rd_first),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
